nes_joypad_port: RTL and testbench

- NES controller-port stage sitting directly downstream of the SOC `keycode` export.
- Converts the USB HID keycode into NES player-1 button state.
- Implements the CPU-visible $4016/$4017 joypad registers:
  - strobe latch on $4016 writes;
  - serial shift-out on $4016 reads;
  - fixed response on $4017 reads.
- Instantiated inside NES_ARCHITECUTRE on the CPU bus, alongside the PPU/APU register decoders.

---
 rtl/nes_joypad_port.sv | 163 ++++++++++++++++
 tb/tb_nes_joypad_port.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_joypad_port.sv
// ---------------------------------------------------------------------------
// nes_joypad_port
//
// NES player-1 controller port. It sits directly downstream of the SOC
// keycode export and turns a USB HID keycode into the 8-bit NES button
// vector. It also implements the CPU-visible joypad registers:
//   $4016 write : bit0 sets the strobe latch
//   $4016 read  : serial shift-out of the latched buttons, LSB first
//   $4017 read  : fixed response (no player 2 is attached)
// Writes to $4017 are ignored because that address belongs to the APU
// frame counter.
//
// Optional feature: define NES_JOYPAD_TURBO_EN to add turbo A (U) and
// turbo B (I) keys, driven by a free-running phase toggle that flips every
// TURBO_PERIOD CPU cycle enables.
//
// Ports
//   Clk          in   system clock (MCLK domain)
//   Reset_n      in   asynchronous active-low reset
//   cpu_ce       in   one-Clk pulse per CPU bus cycle
//   cpu_addr     in   [15:0] CPU address
//   cpu_rw_n     in   1 = read, 0 = write
//   cpu_din      in   [7:0] CPU write data
//   keycode      in   [7:0] USB HID keycode, 0 = no key
//   cpu_dout     out  [7:0] read data (combinational)
//   cpu_dout_en  out  high while this block drives the read bus
//   buttons_dbg  out  [7:0] registered button vector for the LEDs
// ---------------------------------------------------------------------------
module nes_joypad_port #(
  parameter int unsigned TURBO_PERIOD = 59659,
  parameter logic [7:0]  OPEN_BUS     = 8'h40
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw_n,
  input  logic [7:0]  cpu_din,
  input  logic [7:0]  keycode,
  output logic [7:0]  cpu_dout,
  output logic        cpu_dout_en,
  output logic [7:0]  buttons_dbg
);

  localparam logic [15:0] ADDR_JOY1 = 16'h4016;
  localparam logic [15:0] ADDR_JOY2 = 16'h4017;

  logic [7:0] r_btn_q;
  logic       r_strobe;
  logic [7:0] r_sr;

  logic [7:0] w_btn_dec;
  logic       w_hit_joy1;
  logic       w_hit_joy2;
  logic       w_wr_joy1;
  logic       w_rd_joy1;
  logic       w_unused_din;

  // Only bit0 of a $4016 write means anything to the controller.
  assign w_unused_din = ^cpu_din[7:1];

  assign w_hit_joy1 = (cpu_addr == ADDR_JOY1);
  assign w_hit_joy2 = (cpu_addr == ADDR_JOY2);
  assign w_wr_joy1  = cpu_ce & ~cpu_rw_n & w_hit_joy1;
  assign w_rd_joy1  = cpu_ce &  cpu_rw_n & w_hit_joy1;

`ifdef NES_JOYPAD_TURBO_EN
  // Counter width covers 0..TURBO_PERIOD-1; guard the degenerate period.
  localparam int unsigned CNT_W = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURBO_PERIOD - 1);

  logic [CNT_W-1:0] r_turbo_cnt;
  logic             r_turbo_phase;

  // Free-running turbo timebase: it keeps counting whether or not a turbo
  // key is held, so pressing turbo joins the rhythm already in progress.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_turbo_cnt   <= '0;
      r_turbo_phase <= 1'b0;
    end else if (cpu_ce) begin
      if (r_turbo_cnt == CNT_LAST) begin
        r_turbo_cnt   <= '0;
        r_turbo_phase <= ~r_turbo_phase;
      end else begin
        r_turbo_cnt <= r_turbo_cnt + 1'b1;
      end
    end
  end
`endif

  // Keycode to one-hot button decode. A single keycode can only ever
  // select one button, so the vector has at most one bit set.
  always_comb begin
    w_btn_dec = 8'h00;
    case (keycode)
      8'h0E:   w_btn_dec = 8'h01;  // K     -> A
      8'h0D:   w_btn_dec = 8'h02;  // J     -> B
      8'h2C:   w_btn_dec = 8'h04;  // Space -> Select
      8'h28:   w_btn_dec = 8'h08;  // Enter -> Start
      8'h1A:   w_btn_dec = 8'h10;  // W     -> Up
      8'h16:   w_btn_dec = 8'h20;  // S     -> Down
      8'h04:   w_btn_dec = 8'h40;  // A     -> Left
      8'h07:   w_btn_dec = 8'h80;  // D     -> Right
`ifdef NES_JOYPAD_TURBO_EN
      8'h18:   w_btn_dec = {7'b0, r_turbo_phase};        // U -> turbo A
      8'h0C:   w_btn_dec = {6'b0, r_turbo_phase, 1'b0};  // I -> turbo B
`endif
      default: w_btn_dec = 8'h00;
    endcase
  end

  // Register the decoded buttons every clock so the shift register and the
  // LEDs see a glitch-free vector one cycle after the keycode.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_btn_q <= 8'h00;
    end else begin
      r_btn_q <= w_btn_dec;
    end
  end

  // Strobe latch. $4017 writes go to the APU frame counter, not here.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_strobe <= 1'b0;
    end else if (w_wr_joy1) begin
      r_strobe <= cpu_din[0];
    end
  end

  // Shift register. While strobe is high it reloads continuously, so the
  // value left behind by the 1->0 write is the buttons seen in that very
  // cycle. Reads shift in ones from the top, which is why the ninth and
  // later reads return 1, and why the post-reset value of all ones also
  // reads back as 1.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sr <= 8'hFF;
    end else if (r_strobe) begin
      r_sr <= r_btn_q;
    end else if (w_rd_joy1) begin
      r_sr <= {1'b1, r_sr[7:1]};
    end
  end

  // Read mux. The enable is deliberately not qualified by cpu_ce so the
  // bus arbiter sees a stable select for the whole address phase.
  always_comb begin
    cpu_dout    = 8'h00;
    cpu_dout_en = 1'b0;
    if (cpu_rw_n && w_hit_joy1) begin
      cpu_dout    = {OPEN_BUS[7:1], (r_strobe ? r_btn_q[0] : r_sr[0])};
      cpu_dout_en = 1'b1;
    end else if (cpu_rw_n && w_hit_joy2) begin
      cpu_dout    = {OPEN_BUS[7:1], 1'b0};
      cpu_dout_en = 1'b1;
    end
  end

  assign buttons_dbg = r_btn_q;

endmodule

// File: tb/tb_nes_joypad_port.sv
// ---------------------------------------------------------------------------
// tb_nes_joypad_port
//
// Directed bench for nes_joypad_port. Each test task drives a bus scenario
// and compares the read data against hand-computed NES button sequences.
// Inputs change on the falling edge; combinational read data is sampled
// 1 time unit later, registered outputs 1 time unit after the rising edge.
// With NES_JOYPAD_TURBO_EN defined the DUT is built with TURBO_PERIOD=4
// and the turbo toggle is checked as well.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nes_joypad_port;

  logic        Clk;
  logic        Reset_n;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic        cpu_rw_n;
  logic [7:0]  cpu_din;
  logic [7:0]  keycode;
  logic [7:0]  cpu_dout;
  logic        cpu_dout_en;
  logic [7:0]  buttons_dbg;

  int nChecks = 0;
  int nFail   = 0;

`ifdef NES_JOYPAD_TURBO_EN
  nes_joypad_port #(.TURBO_PERIOD(4), .OPEN_BUS(8'h40)) dut (
`else
  nes_joypad_port #(.OPEN_BUS(8'h40)) dut (
`endif
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .cpu_ce      (cpu_ce),
    .cpu_addr    (cpu_addr),
    .cpu_rw_n    (cpu_rw_n),
    .cpu_din     (cpu_din),
    .keycode     (keycode),
    .cpu_dout    (cpu_dout),
    .cpu_dout_en (cpu_dout_en),
    .buttons_dbg (buttons_dbg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One CPU read cycle; returns the combinational read data of that cycle.
  task automatic applyRead(input logic [15:0] a, output logic [7:0] d, output logic en);
    @(negedge Clk);
    cpu_ce   = 1'b1;
    cpu_rw_n = 1'b1;
    cpu_addr = a;
    #1;
    d  = cpu_dout;
    en = cpu_dout_en;
    @(posedge Clk);
    #1;
    cpu_ce   = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  // One CPU write cycle.
  task automatic applyWrite(input logic [15:0] a, input logic [7:0] v);
    @(negedge Clk);
    cpu_ce   = 1'b1;
    cpu_rw_n = 1'b0;
    cpu_addr = a;
    cpu_din  = v;
    @(posedge Clk);
    #1;
    cpu_ce   = 1'b0;
    cpu_rw_n = 1'b1;
    cpu_addr = 16'h0000;
    cpu_din  = 8'h00;
  endtask

  task automatic applyIdle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Reset state, then nine reads of an empty controller all return 1.
  task automatic test_reset();
    logic [7:0] d;
    logic       en;
    Reset_n  = 1'b0;
    cpu_ce   = 1'b0;
    cpu_rw_n = 1'b1;
    cpu_addr = 16'h0000;
    cpu_din  = 8'h00;
    keycode  = 8'h28;
    applyIdle(3);
    nChecks++;
    if (buttons_dbg !== 8'h00) begin
      nFail++;
      $display("[TB] FAIL reset_buttons: got %h expected 00", buttons_dbg);
    end
    nChecks++;
    if (cpu_dout !== 8'h00 || cpu_dout_en !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_idle_bus: got dout=%h en=%b expected 00/0", cpu_dout, cpu_dout_en);
    end
    keycode = 8'h00;
    @(negedge Clk);
    Reset_n = 1'b1;
    applyIdle(2);
    for (int i = 0; i < 9; i++) begin
      applyRead(16'h4016, d, en);
      nChecks++;
      if (d !== 8'h41 || en !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL empty_read%0d: got dout=%h en=%b expected 41/1", i, d, en);
      end
    end
  endtask

  // Latch Start and shift it out: 0,0,0,1,0,0,0,0 then 1.
  task automatic test_start_shift();
    logic [7:0] d;
    logic       en;
    logic [7:0] btn;
    logic       exp;
    btn = 8'h08;
    keycode = 8'h28;
    applyIdle(2);
    applyWrite(16'h4016, 8'h01);
    applyWrite(16'h4016, 8'h00);
    for (int i = 0; i < 9; i++) begin
      exp = (i < 8) ? btn[i] : 1'b1;
      applyRead(16'h4016, d, en);
      nChecks++;
      if (d !== {7'b0100000, exp}) begin
        nFail++;
        $display("[TB] FAIL start_read%0d: got %h expected %h", i, d, {7'b0100000, exp});
      end
    end
  endtask

  // With strobe held, reads return live A and do not shift.
  task automatic test_strobe_held();
    logic [7:0] d;
    logic       en;
    logic [7:0] btn;
    logic       exp;
    btn = 8'h01;
    keycode = 8'h0E;
    applyIdle(2);
    applyWrite(16'h4016, 8'h01);
    for (int i = 0; i < 3; i++) begin
      applyRead(16'h4016, d, en);
      nChecks++;
      if (d !== 8'h41) begin
        nFail++;
        $display("[TB] FAIL strobe_held_read%0d: got %h expected 41", i, d);
      end
    end
    applyWrite(16'h4016, 8'hFE);
    for (int i = 0; i < 9; i++) begin
      exp = (i < 8) ? btn[i] : 1'b1;
      applyRead(16'h4016, d, en);
      nChecks++;
      if (d[0] !== exp) begin
        nFail++;
        $display("[TB] FAIL a_read%0d: got %b expected %b", i, d[0], exp);
      end
    end
  endtask

  // Keycode changes mid-sequence must not disturb the latched Right.
  task automatic test_key_change();
    logic [7:0] d;
    logic       en;
    keycode = 8'h07;
    applyIdle(2);
    applyWrite(16'h4016, 8'h01);
    applyWrite(16'h4016, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        keycode = 8'h04;
        applyIdle(2);
        nChecks++;
        if (buttons_dbg !== 8'h40) begin
          nFail++;
          $display("[TB] FAIL left_buttons: got %h expected 40", buttons_dbg);
        end
      end
      applyRead(16'h4016, d, en);
      nChecks++;
      if (d[0] !== (i == 7)) begin
        nFail++;
        $display("[TB] FAIL right_read%0d: got %b expected %b", i, d[0], (i == 7));
      end
    end
  endtask

  // $4017 reads are fixed and do not shift; $4017 writes do not strobe.
  task automatic test_port2();
    logic [7:0] d;
    logic       en;
    keycode = 8'h0D;
    applyIdle(2);
    applyWrite(16'h4016, 8'h01);
    applyWrite(16'h4016, 8'h00);
    applyRead(16'h4016, d, en);
    nChecks++;
    if (d[0] !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL b_read0: got %b expected 0", d[0]);
    end
    for (int i = 0; i < 2; i++) begin
      applyRead(16'h4017, d, en);
      nChecks++;
      if (d !== 8'h40 || en !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL port2_read%0d: got dout=%h en=%b expected 40/1", i, d, en);
      end
    end
    applyRead(16'h4016, d, en);
    nChecks++;
    if (d[0] !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL b_read1: got %b expected 1", d[0]);
    end
    applyWrite(16'h4017, 8'h01);
    for (int i = 2; i < 9; i++) begin
      applyRead(16'h4016, d, en);
      nChecks++;
      if (d[0] !== (i == 8)) begin
        nFail++;
        $display("[TB] FAIL b_read%0d: got %b expected %b", i, d[0], (i == 8));
      end
    end
    // Unrelated address: bus released.
    applyRead(16'h2002, d, en);
    nChecks++;
    if (d !== 8'h00 || en !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL other_addr: got dout=%h en=%b expected 00/0", d, en);
    end
    // Enable follows address and direction even without cpu_ce.
    @(negedge Clk);
    cpu_addr = 16'h4017;
    cpu_rw_n = 1'b1;
    #1;
    nChecks++;
    if (cpu_dout_en !== 1'b1 || cpu_dout !== 8'h40) begin
      nFail++;
      $display("[TB] FAIL en_no_ce: got dout=%h en=%b expected 40/1", cpu_dout, cpu_dout_en);
    end
    cpu_addr = 16'h0000;
  endtask

  // Asynchronous reset mid-sequence restores sr=FF, strobe=0, buttons=00.
  task automatic test_reset_midseq();
    logic [7:0] d;
    logic       en;
    keycode = 8'h28;
    applyIdle(2);
    applyWrite(16'h4016, 8'h01);
    applyWrite(16'h4016, 8'h00);
    for (int i = 0; i < 4; i++) begin
      applyRead(16'h4016, d, en);
      nChecks++;
      if (d[0] !== (i == 3)) begin
        nFail++;
        $display("[TB] FAIL pre_reset_read%0d: got %b expected %b", i, d[0], (i == 3));
      end
    end
    #2;
    Reset_n = 1'b0;
    #1;
    nChecks++;
    if (buttons_dbg !== 8'h00) begin
      nFail++;
      $display("[TB] FAIL midreset_buttons: got %h expected 00", buttons_dbg);
    end
    cpu_addr = 16'h4016;
    #1;
    nChecks++;
    if (cpu_dout !== 8'h41 || cpu_dout_en !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL midreset_dout: got dout=%h en=%b expected 41/1", cpu_dout, cpu_dout_en);
    end
    cpu_addr = 16'h0000;
    @(negedge Clk);
    Reset_n = 1'b1;
    applyIdle(2);
    for (int i = 0; i < 3; i++) begin
      applyRead(16'h4016, d, en);
      nChecks++;
      if (d !== 8'h41) begin
        nFail++;
        $display("[TB] FAIL post_reset_read%0d: got %h expected 41", i, d);
      end
    end
  endtask

  // Keycode map with one-cycle latency into buttons_dbg.
  task automatic test_keymap();
    logic [7:0] keys [0:11];
    logic [7:0] exps [0:11];
    keys = '{8'h0E, 8'h0D, 8'h2C, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07,
             8'h05, 8'h00, 8'h18, 8'h0C};
    exps = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
             8'h00, 8'h00, 8'h00, 8'h00};
`ifdef NES_JOYPAD_TURBO_EN
    for (int i = 0; i < 10; i++) begin
`else
    for (int i = 0; i < 12; i++) begin
`endif
      @(negedge Clk);
      keycode = keys[i];
      @(posedge Clk);
      #1;
      nChecks++;
      if (buttons_dbg !== exps[i]) begin
        nFail++;
        $display("[TB] FAIL keymap_%h: got %h expected %h", keys[i], buttons_dbg, exps[i]);
      end
    end
  endtask

`ifdef NES_JOYPAD_TURBO_EN
  // Turbo A toggles every 4 cpu_ce pulses after reset; turbo B on bit1.
  task automatic test_turbo();
    logic exp;
    @(negedge Clk);
    keycode = 8'h18;
    cpu_ce  = 1'b0;
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge Clk);
      cpu_ce = 1'b1;
      @(negedge Clk);
      cpu_ce = 1'b0;
      @(posedge Clk);
      #1;
      exp = ((n / 4) % 2) == 1;
      nChecks++;
      if (buttons_dbg !== {7'b0, exp}) begin
        nFail++;
        $display("[TB] FAIL turbo_a_%0d: got %h expected %h", n, buttons_dbg, {7'b0, exp});
      end
    end
    @(negedge Clk);
    keycode = 8'h0C;
    @(posedge Clk);
    #1;
    nChecks++;
    if (buttons_dbg !== 8'h02) begin
      nFail++;
      $display("[TB] FAIL turbo_b: got %h expected 02", buttons_dbg);
    end
  endtask
`endif

  initial begin
    $display("[TB] nes_joypad_port bench start");
    test_reset();
    test_start_shift();
    test_strobe_held();
    test_key_change();
    test_port2();
    test_reset_midseq();
    test_keymap();
`ifdef NES_JOYPAD_TURBO_EN
    test_turbo();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
